// File: rtl/as6d_pldb_sched_pkg.sv
// Shared definitions for the PCS RX payload-buffer round-robin read scheduler.
// Contents: scheduler state encoding, lane-index width helper, default EOP bit.
// Imported by as6d_pldb_rr_arb and as6d_pcs_rx_pldb_rr_sched.
package as6d_pldb_sched_pkg;

  // IDLE arbitrates; XFER drains the granted lane until EOP or watchdog release.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_e;

  // End-of-packet marker position in a 72-bit payload-buffer word.
  localparam int DEF_EOP_BIT = 71;

  // Width of a lane index (ceil(log2(n))), never narrower than one bit.
  function automatic int LANE_IDX_W(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/as6d_pldb_rr_arb.sv
// Rotating-priority one-hot picker: grants the first requesting lane at or
// after ptr_i, wrapping cyclically. Purely combinational.
// Ports: req_i (per-lane request), ptr_i (priority start lane),
//        gnt_o (one-hot grant, zero when no request), no_req_o (req_i == 0).
module as6d_pldb_rr_arb
  import as6d_pldb_sched_pkg::*;
#(
  parameter int LANE_NUM = 4,
  parameter int IDX_W    = LANE_IDX_W(LANE_NUM)
) (
  input  logic [LANE_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [LANE_NUM-1:0] gnt_o,
  output logic                no_req_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    // Walk lanes starting at the pointer; the first hit wins.
    for (int k = 0; k < LANE_NUM; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % LANE_NUM);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign no_req_o = ~|req_i;

endmodule

// File: rtl/as6d_pcs_rx_pldb_rr_sched.sv
// Packet-aware round-robin read scheduler draining LANE_NUM FWFT payload-buffer
// FIFOs into one registered 72-bit stream. A lane holds the grant until EOP; a
// mid-packet stall of cfg_tmo empty cycles releases it and pulses tmo_int.
// Ports: clk/rst (sync, active-high); cfg_lane_en, cfg_tmo; per-lane
//   fifo_empty/fifo_rd_data in, fifo_rd_en out; out_data/out_valid/out_lane
//   with out_ready; grant (one-hot); tmo_int.
// Optional: define AS6D_PLDB_SCHED_STAT_EN to add per-lane saturating packet
//   counters (stat_clr, stat_sel in; stat_pkt_cnt out, 1-cycle read latency).
// Latency: FIFO head to out_data is one cycle; one arbitration cycle per packet.
module as6d_pcs_rx_pldb_rr_sched
  import as6d_pldb_sched_pkg::*;
#(
  parameter int LANE_NUM   = 4,
  parameter int DATA_WIDTH = 72,
  parameter int EOP_BIT    = DEF_EOP_BIT,
  parameter int TMO_WIDTH  = 8,
  parameter int IDX_W      = LANE_IDX_W(LANE_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LANE_NUM-1:0]            cfg_lane_en,
  input  logic [TMO_WIDTH-1:0]           cfg_tmo,
  input  logic [LANE_NUM-1:0]            fifo_empty,
  input  logic [LANE_NUM*DATA_WIDTH-1:0] fifo_rd_data,
  output logic [LANE_NUM-1:0]            fifo_rd_en,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_lane,
  output logic [LANE_NUM-1:0]            grant,
  output logic                           tmo_int
`ifdef AS6D_PLDB_SCHED_STAT_EN
  ,
  input  logic                           stat_clr,
  input  logic [IDX_W-1:0]               stat_sel,
  output logic [15:0]                    stat_pkt_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  sched_state_e          state_q;
  logic [LANE_NUM-1:0]   grant_q;
  logic [IDX_W-1:0]      gidx_q;      // index form of grant_q
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [TMO_WIDTH-1:0]  tmo_cnt_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic [IDX_W-1:0]      out_lane_q;
  logic                  tmo_int_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [LANE_NUM-1:0]   req;
  logic [LANE_NUM-1:0]   arb_gnt;
  logic                  arb_no_req;
  logic [IDX_W-1:0]      arb_idx;
  logic [DATA_WIDTH-1:0] lane_word [LANE_NUM];
  logic [DATA_WIDTH-1:0] head;
  logic                  head_eop;
  logic                  g_empty;
  logic                  can_load;
  logic                  pop;
  logic                  tmo_hit;
  logic [IDX_W-1:0]      ptr_nxt;

  assign req = cfg_lane_en & ~fifo_empty;

  as6d_pldb_rr_arb #(
    .LANE_NUM (LANE_NUM),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .no_req_o (arb_no_req)
  );

  always_comb begin
    arb_idx = '0;
    for (int l = 0; l < LANE_NUM; l++) begin
      if (arb_gnt[l]) begin
        arb_idx = IDX_W'(l);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANE_NUM; l++) begin
      lane_word[l] = fifo_rd_data[l*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign head     = lane_word[gidx_q];
  assign head_eop = head[EOP_BIT];
  assign g_empty  = fifo_empty[gidx_q];

  // The output register can take a new word when it is empty or being drained.
  assign can_load = ~out_valid_q | out_ready;

  // Pop depends only on registered grant, empty flag and out_ready, never on
  // the FIFO data, so no data-to-rd_en path exists.
  assign pop        = (state_q == XFER) & ~g_empty & can_load;
  assign fifo_rd_en = pop ? grant_q : '0;

  // Watchdog fires on the cfg_tmo-th consecutive empty cycle of the granted lane.
  assign tmo_hit = (state_q == XFER) & g_empty & (cfg_tmo != '0) &
                   (tmo_cnt_q == (cfg_tmo - TMO_WIDTH'(1)));

  assign ptr_nxt = (gidx_q == IDX_W'(LANE_NUM - 1)) ? '0 : (gidx_q + IDX_W'(1));

  // ---------------------------------------------------------------------------
  // Scheduler FSM, output register and watchdog
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      tmo_int_q   <= 1'b0;
    end else begin
      tmo_int_q <= 1'b0;

      if (pop) begin
        out_data_q  <= head;
        out_valid_q <= 1'b1;
        out_lane_q  <= gidx_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          if (!arb_no_req) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            state_q <= XFER;
          end
        end

        XFER: begin
          if (pop) begin
            tmo_cnt_q <= '0;
            if (head_eop) begin
              grant_q  <= '0;
              rr_ptr_q <= ptr_nxt;
              state_q  <= IDLE;
            end
          end else if (tmo_hit) begin
            // Partial packet is left unterminated downstream.
            tmo_int_q <= 1'b1;
            grant_q   <= '0;
            rr_ptr_q  <= ptr_nxt;
            state_q   <= IDLE;
          end else if (g_empty && (tmo_cnt_q != '1)) begin
            // Only empty cycles count; stalls from out_ready do not.
            tmo_cnt_q <= tmo_cnt_q + TMO_WIDTH'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_lane  = out_lane_q;
  assign grant     = grant_q;
  assign tmo_int   = tmo_int_q;

`ifdef AS6D_PLDB_SCHED_STAT_EN
  // ---------------------------------------------------------------------------
  // Per-lane completed-packet counters (saturating)
  // ---------------------------------------------------------------------------
  logic [15:0] pkt_cnt_q [LANE_NUM];
  logic [15:0] pkt_cnt_d [LANE_NUM];
  logic [15:0] stat_pkt_cnt_q;
  logic [15:0] stat_pkt_cnt_d;
  logic        eop_pop;

  assign eop_pop = pop & head_eop;

  always_comb begin
    for (int l = 0; l < LANE_NUM; l++) begin
      pkt_cnt_d[l] = pkt_cnt_q[l];
      if (stat_clr) begin
        pkt_cnt_d[l] = '0;
      end else if (eop_pop && (gidx_q == IDX_W'(l)) && (pkt_cnt_q[l] != 16'hFFFF)) begin
        pkt_cnt_d[l] = pkt_cnt_q[l] + 16'd1;
      end
    end
  end

  // Selects beyond LANE_NUM (non-power-of-two lane counts) read as zero.
  always_comb begin
    stat_pkt_cnt_d = '0;
    if (int'(stat_sel) < LANE_NUM) begin
      stat_pkt_cnt_d = pkt_cnt_q[stat_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANE_NUM; l++) begin
        pkt_cnt_q[l] <= '0;
      end
      stat_pkt_cnt_q <= '0;
    end else begin
      for (int l = 0; l < LANE_NUM; l++) begin
        pkt_cnt_q[l] <= pkt_cnt_d[l];
      end
      stat_pkt_cnt_q <= stat_pkt_cnt_d;
    end
  end

  assign stat_pkt_cnt = stat_pkt_cnt_q;
`endif

endmodule

// File: tb/tb_as6d_pcs_rx_pldb_rr_sched.sv
// Directed bench for the payload-buffer round-robin scheduler: a table of
// multi-lane packet scenarios plus hand-written backpressure, watchdog and
// mid-packet reset sequences. FIFOs are modelled as per-lane queues.
module tb_as6d_pcs_rx_pldb_rr_sched;

  localparam int LN = 4;
  localparam int DW = 72;
  localparam int NLOG = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [LN-1:0]     cfg_lane_en;
  logic [7:0]        cfg_tmo;
  logic [LN-1:0]     fifo_empty;
  logic [LN*DW-1:0]  fifo_rd_data;
  logic [LN-1:0]     fifo_rd_en;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_lane;
  logic [LN-1:0]     grant;
  logic              tmo_int;

  always #5 clk = ~clk;

  as6d_pcs_rx_pldb_rr_sched dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_lane_en  (cfg_lane_en),
    .cfg_tmo      (cfg_tmo),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane     (out_lane),
    .grant        (grant),
    .tmo_int      (tmo_int)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Word tag: EOP flag, lane, packet number within lane, word index.
  function automatic logic [71:0] mkw(input int lane, input int pk, input int s, input bit eop);
    return {eop, 7'h0, 8'(lane), 8'(pk), 8'(s), 40'hC0_FFEE_1234};
  endfunction

  // FIFO models and per-cycle logs
  logic [71:0] fq [LN][$];
  logic        rst_pat [NLOG];
  logic        rdy_pat [NLOG];
  logic [3:0]  lg_gnt  [NLOG];
  logic [3:0]  lg_rden [NLOG];
  logic        lg_vld  [NLOG];
  logic [1:0]  lg_lane [NLOG];
  logic [71:0] lg_dat  [NLOG];
  logic        lg_tmo  [NLOG];
  int          rden_bad;

  task automatic drive_fifo();
    for (int l = 0; l < LN; l++) begin
      fifo_empty[l] = (fq[l].size() == 0);
      if (fq[l].size() == 0) fifo_rd_data[l*DW +: DW] = '0;
      else                   fifo_rd_data[l*DW +: DW] = fq[l][0];
    end
  endtask

  task automatic flush_fifos();
    for (int l = 0; l < LN; l++) fq[l].delete();
    drive_fifo();
  endtask

  task automatic clear_pats();
    for (int c = 0; c < NLOG; c++) begin
      rst_pat[c] = 1'b0;
      rdy_pat[c] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle c begins 1 time unit after a rising edge; outputs logged at negedge.
  task automatic run_cycles(input int n);
    logic [3:0] rd_s;
    rden_bad = 0;
    for (int c = 0; c < n; c++) begin
      rst       = rst_pat[c];
      out_ready = rdy_pat[c];
      drive_fifo();
      @(negedge clk);
      lg_gnt[c]  = grant;
      lg_rden[c] = fifo_rd_en;
      lg_vld[c]  = out_valid;
      lg_lane[c] = out_lane;
      lg_dat[c]  = out_data;
      lg_tmo[c]  = tmo_int;
      if ((fifo_rd_en & fifo_empty) != 4'b0) rden_bad++;
      rd_s = fifo_rd_en;
      @(posedge clk);
      #1;
      for (int l = 0; l < LN; l++)
        if (rd_s[l] && fq[l].size() > 0) void'(fq[l].pop_front());
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    drive_fifo();
    chk("rd_en on empty lane", rden_bad, 0);
  endtask

  // Scenario table: nibble l of len/npk is lane l; nibble p of order is the
  // lane of the p-th expected packet; last_pop is the cycle of the final pop.
  typedef struct packed {
    logic        do_rst;
    logic [3:0]  en;
    logic [15:0] len;
    logic [15:0] npk;
    logic [3:0]  n_exp;
    logic [31:0] order;
    logic [7:0]  last_pop;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [71:0] exp_q [$];
    logic [1:0]  expl_q [$];
    int          kcnt [LN];
    int          lastp, nw, na, ntmo, lane, plen;

    vecs[0] = '{1'b1, 4'b1111, 16'h0003, 16'h0001, 4'd1, 32'h0000_0000, 8'd3};
    vecs[1] = '{1'b1, 4'b1111, 16'h2222, 16'h1111, 4'd4, 32'h0000_3210, 8'd11};
    vecs[2] = '{1'b0, 4'b1111, 16'h0011, 16'h0011, 4'd2, 32'h0000_0010, 8'd3};
    vecs[3] = '{1'b0, 4'b1111, 16'h1011, 16'h1011, 4'd3, 32'h0000_0103, 8'd5};
    vecs[4] = '{1'b0, 4'b1010, 16'h2121, 16'h2222, 4'd4, 32'h0000_1313, 8'd11};
    vecs[5] = '{1'b1, 4'b1111, 16'h1231, 16'h1111, 4'd4, 32'h0000_3210, 8'd10};
    vecs[6] = '{1'b0, 4'b0100, 16'h4444, 16'h1111, 4'd1, 32'h0000_0002, 8'd4};

    rst = 1'b1;
    cfg_lane_en = 4'b1111;
    cfg_tmo = 8'd0;
    out_ready = 1'b1;
    flush_fifos();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("reset grant", grant, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_lane", out_lane, 0);
    chk("reset tmo_int", tmo_int, 0);
    chk("reset rd_en", fifo_rd_en, 0);
    @(posedge clk);
    #1;

    // Table-driven scenarios
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_rst) do_reset();
      cfg_lane_en = vecs[v].en;
      cfg_tmo = 8'd0;
      for (int l = 0; l < LN; l++) begin
        kcnt[l] = 0;
        for (int p = 0; p < int'(vecs[v].npk[4*l +: 4]); p++) begin
          plen = int'(vecs[v].len[4*l +: 4]);
          for (int s = 0; s < plen; s++) fq[l].push_back(mkw(l, p, s, s == plen - 1));
        end
      end
      exp_q.delete();
      expl_q.delete();
      for (int p = 0; p < int'(vecs[v].n_exp); p++) begin
        lane = int'(vecs[v].order[4*p +: 4]);
        plen = int'(vecs[v].len[4*lane +: 4]);
        for (int s = 0; s < plen; s++) begin
          exp_q.push_back(mkw(lane, kcnt[lane], s, s == plen - 1));
          expl_q.push_back(2'(lane));
        end
        kcnt[lane]++;
      end
      clear_pats();
      run_cycles(40);
      lastp = -1;
      nw = 0;
      for (int c = 0; c < 40; c++) begin
        if (lg_rden[c] != 4'b0) lastp = c;
        if (lg_vld[c]) begin
          if (nw < exp_q.size()) begin
            chk($sformatf("v%0d word%0d data", v, nw), lg_dat[c], exp_q[nw]);
            chk($sformatf("v%0d word%0d lane", v, nw), lg_lane[c], expl_q[nw]);
          end
          nw++;
        end
      end
      chk($sformatf("v%0d word count", v), nw, exp_q.size());
      chk($sformatf("v%0d last pop cycle", v), lastp, vecs[v].last_pop);
      chk($sformatf("v%0d final grant", v), lg_gnt[39], 0);
      flush_fifos();
    end

    // Single 3-word packet on lane0: arbitration in cycle 0, pops 1..3, valid 2..4
    do_reset();
    cfg_lane_en = 4'b1111;
    cfg_tmo = 8'd0;
    for (int s = 0; s < 3; s++) fq[0].push_back(mkw(0, 0, s, s == 2));
    clear_pats();
    run_cycles(8);
    chk("t1 grant c0", lg_gnt[0], 4'b0000);
    chk("t1 rd_en c0", lg_rden[0], 4'b0000);
    chk("t1 grant c1", lg_gnt[1], 4'b0001);
    chk("t1 rd_en c1", lg_rden[1], 4'b0001);
    chk("t1 rd_en c3", lg_rden[3], 4'b0001);
    chk("t1 rd_en c4", lg_rden[4], 4'b0000);
    chk("t1 valid c1", lg_vld[1], 0);
    chk("t1 valid c2", lg_vld[2], 1);
    chk("t1 data c2", lg_dat[2], mkw(0, 0, 0, 0));
    chk("t1 valid c4", lg_vld[4], 1);
    chk("t1 data c4", lg_dat[4], mkw(0, 0, 2, 1));
    chk("t1 valid c5", lg_vld[5], 0);
    chk("t1 grant c4", lg_gnt[4], 4'b0000);
    flush_fifos();

    // Backpressure on lane1 for cycles 2..6: no pops, data held, no watchdog
    do_reset();
    cfg_tmo = 8'd2;
    for (int s = 0; s < 4; s++) fq[1].push_back(mkw(1, 0, s, s == 3));
    clear_pats();
    for (int c = 2; c <= 6; c++) rdy_pat[c] = 1'b0;
    run_cycles(16);
    for (int c = 2; c <= 6; c++) begin
      chk($sformatf("bp rd_en c%0d", c), lg_rden[c], 4'b0000);
      chk($sformatf("bp data c%0d", c), lg_dat[c], mkw(1, 0, 0, 0));
    end
    na = 0;
    ntmo = 0;
    for (int c = 0; c < 16; c++) begin
      if (lg_tmo[c]) ntmo++;
      if (lg_vld[c] && rdy_pat[c]) begin
        chk($sformatf("bp accepted%0d", na), lg_dat[c], mkw(1, 0, na, na == 3));
        chk($sformatf("bp lane%0d", na), lg_lane[c], 2'd1);
        na++;
      end
    end
    chk("bp accepted count", na, 4);
    chk("bp tmo pulses", ntmo, 0);
    flush_fifos();

    // Watchdog: lane2 stalls after one word, cfg_tmo=4, lane3 waiting
    do_reset();
    cfg_tmo = 8'd4;
    fq[2].push_back(mkw(2, 0, 0, 0));
    fq[3].push_back(mkw(3, 0, 0, 0));
    fq[3].push_back(mkw(3, 0, 1, 1));
    clear_pats();
    run_cycles(16);
    ntmo = 0;
    for (int c = 0; c < 16; c++) if (lg_tmo[c]) ntmo++;
    chk("tmo pulse count", ntmo, 1);
    chk("tmo pulse c6", lg_tmo[6], 1);
    chk("tmo grant c5", lg_gnt[5], 4'b0100);
    chk("tmo grant c6", lg_gnt[6], 4'b0000);
    chk("tmo grant c7", lg_gnt[7], 4'b1000);
    exp_q.delete();
    exp_q.push_back(mkw(2, 0, 0, 0));
    exp_q.push_back(mkw(3, 0, 0, 0));
    exp_q.push_back(mkw(3, 0, 1, 1));
    nw = 0;
    for (int c = 0; c < 16; c++) begin
      if (lg_vld[c]) begin
        if (nw < exp_q.size()) chk($sformatf("tmo word%0d", nw), lg_dat[c], exp_q[nw]);
        nw++;
      end
    end
    chk("tmo word count", nw, 3);
    flush_fifos();

    // Reset in the middle of a lane0 packet
    do_reset();
    cfg_tmo = 8'd0;
    for (int s = 0; s < 5; s++) fq[0].push_back(mkw(0, 0, s, s == 4));
    clear_pats();
    rst_pat[3] = 1'b1;
    run_cycles(8);
    chk("mrst valid before", lg_vld[3], 1);
    chk("mrst valid after", lg_vld[4], 0);
    chk("mrst grant after", lg_gnt[4], 4'b0000);
    chk("mrst data after", lg_dat[4], 0);
    chk("mrst rd_en after", lg_rden[4], 4'b0000);
    flush_fifos();
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
